// File: rtl/ras_pkg.sv
// rtl/ras_pkg.sv - shared predictor types and return-address-stack state definitions
package ras_pkg;

  typedef enum logic [2:0] {
    INS_NONE     = 3'b000,
    INS_BRANCH   = 3'b001,
    INS_JUMP     = 3'b010,
    INS_CALL     = 3'b011,
    INS_RETURN   = 3'b100,
    INS_INDIRECT = 3'b101
  } ins_type_e;

  localparam int RAS_NUM_DEF = 8;
  localparam int SP_W        = $clog2(RAS_NUM_DEF);
  localparam int CNT_W       = $clog2(RAS_NUM_DEF) + 1;

  typedef struct packed {
    logic [RAS_NUM_DEF-1:0][31:0] entries;
    logic [SP_W-1:0]              sp;
    logic [CNT_W-1:0]             count;
  } ras_state_t;

  // Stack pointer move modulo the configured depth (up = push direction).
  function automatic logic [SP_W-1:0] sp_step(input logic [SP_W-1:0] sp, input logic up,
                                              input int depth);
    int t;
    t = up ? (int'(sp) + 1) : (int'(sp) + depth - 1);
    return SP_W'(t % depth);
  endfunction

endpackage

// File: rtl/ras_step.sv
// rtl/ras_step.sv - combinational push/pop next-state for one return-address stack
module ras_step
  import ras_pkg::*;
#(
  parameter int RASNUM = RAS_NUM_DEF
) (
  input  ras_state_t  cur,
  input  logic        valid,
  input  logic [2:0]  ins_type,
  input  logic [31:0] pc,
  output ras_state_t  nxt
);

  always_comb begin
    nxt = cur;
    if (valid && ins_type == INS_CALL) begin
      nxt.entries[cur.sp] = pc + 32'd4;
      nxt.sp = sp_step(cur.sp, 1'b1, RASNUM);
      // A full stack keeps its count; the oldest slot is the one just overwritten.
      if (cur.count != CNT_W'(RASNUM)) nxt.count = cur.count + 1'b1;
    end else if (valid && ins_type == INS_RETURN && cur.count != '0) begin
      nxt.sp    = sp_step(cur.sp, 1'b0, RASNUM);
      nxt.count = cur.count - 1'b1;
    end
  end

endmodule

// File: rtl/ras.sv
// rtl/ras.sv - speculative/committed return address stack with repair; RAS_PERF_CNT_EN adds push/pop counters
module ras
  import ras_pkg::*;
#(
  parameter int RASNUM = RAS_NUM_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pred_valid,
  input  logic [2:0]  pred_ins_type,
  input  logic [31:0] pred_pc,
  output logic [31:0] ras_top,
  output logic        ras_valid,
  input  logic        cmt_valid,
  input  logic [2:0]  cmt_ins_type,
  input  logic [31:0] cmt_pc,
  input  logic        repair_valid,
  input  logic [2:0]  repair_ins_type,
`ifdef RAS_PERF_CNT_EN
  input  logic [31:0] repair_pc,
  output logic [31:0] ras_push_cnt,
  output logic [31:0] ras_pop_cnt
`else
  input  logic [31:0] repair_pc
`endif
);

  ras_state_t spec_q, cmt_q;
  ras_state_t spec_pred_d, cmt_d, spec_rep_d;

  ras_step #(.RASNUM(RASNUM)) u_step_cmt (
    .cur(cmt_q), .valid(cmt_valid), .ins_type(cmt_ins_type), .pc(cmt_pc), .nxt(cmt_d)
  );

  // Repair rebuilds from the committed stack including this cycle's commit.
  ras_step #(.RASNUM(RASNUM)) u_step_repair (
    .cur(cmt_d), .valid(1'b1), .ins_type(repair_ins_type), .pc(repair_pc), .nxt(spec_rep_d)
  );

  ras_step #(.RASNUM(RASNUM)) u_step_spec (
    .cur(spec_q), .valid(pred_valid), .ins_type(pred_ins_type), .pc(pred_pc), .nxt(spec_pred_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      spec_q.sp    <= '0;
      spec_q.count <= '0;
      cmt_q.sp     <= '0;
      cmt_q.count  <= '0;
    end else begin
      spec_q <= repair_valid ? spec_rep_d : spec_pred_d;
      cmt_q  <= cmt_d;
    end
  end

  assign ras_valid = (spec_q.count != '0);
  assign ras_top   = ras_valid ? spec_q.entries[sp_step(spec_q.sp, 1'b0, RASNUM)] : 32'b0;

`ifdef RAS_PERF_CNT_EN
  logic spec_push, spec_pop;

  assign spec_push = repair_valid ? (repair_ins_type == INS_CALL)
                                  : (pred_valid && pred_ins_type == INS_CALL);
  assign spec_pop  = repair_valid ? (repair_ins_type == INS_RETURN && cmt_d.count != '0)
                                  : (pred_valid && pred_ins_type == INS_RETURN && spec_q.count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ras_push_cnt <= '0;
      ras_pop_cnt  <= '0;
    end else begin
      if (spec_push) ras_push_cnt <= ras_push_cnt + 32'd1;
      if (spec_pop)  ras_pop_cnt  <= ras_pop_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ras.sv
// tb/tb_ras.sv - directed self-checking bench for the return address stack
module tb_ras;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [2:0]  pred_ins_type;
  logic [31:0] pred_pc;
  logic [31:0] ras_top;
  logic        ras_valid;
  logic        cmt_valid;
  logic [2:0]  cmt_ins_type;
  logic [31:0] cmt_pc;
  logic        repair_valid;
  logic [2:0]  repair_ins_type;
  logic [31:0] repair_pc;
`ifdef RAS_PERF_CNT_EN
  logic [31:0] ras_push_cnt;
  logic [31:0] ras_pop_cnt;
`endif

  localparam logic [2:0] T_JUMP = 3'b010;
  localparam logic [2:0] T_CALL = 3'b011;
  localparam logic [2:0] T_RET  = 3'b100;

  int checks = 0;
  int errors = 0;

  ras dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_ins_type(pred_ins_type), .pred_pc(pred_pc),
    .ras_top(ras_top), .ras_valid(ras_valid),
    .cmt_valid(cmt_valid), .cmt_ins_type(cmt_ins_type), .cmt_pc(cmt_pc),
    .repair_valid(repair_valid), .repair_ins_type(repair_ins_type),
`ifdef RAS_PERF_CNT_EN
    .repair_pc(repair_pc), .ras_push_cnt(ras_push_cnt), .ras_pop_cnt(ras_pop_cnt)
`else
    .repair_pc(repair_pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0;
    pred_valid = 1'b0; pred_ins_type = 3'b000; pred_pc = 32'h0;
    cmt_valid = 1'b0; cmt_ins_type = 3'b000; cmt_pc = 32'h0;
    repair_valid = 1'b0; repair_ins_type = 3'b000; repair_pc = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic pred(input logic [2:0] t, input logic [31:0] pc);
    idle();
    pred_valid = 1'b1; pred_ins_type = t; pred_pc = pc;
    tick();
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);

    do_reset();
    chk("reset_valid", 32'(ras_valid), 32'd0);
    chk("reset_top", ras_top, 32'h0);

    pred(T_CALL, 32'h1C00_0000);
    chk("call_top", ras_top, 32'h1C00_0004);
    chk("call_valid", 32'(ras_valid), 32'd1);

    do_reset();
    for (int i = 1; i <= 9; i++) pred(T_CALL, 32'(i) * 32'h100);
    chk("full_count", 32'(dut.spec_q.count), 32'd8);
    chk("full_top", ras_top, 32'h904);
    chk("full_sp", 32'(dut.spec_q.sp), 32'd1);
    for (int i = 9; i >= 2; i--) begin
      chk($sformatf("pop_top_%0d", i), ras_top, 32'(i) * 32'h100 + 32'h4);
      pred(T_RET, 32'h0);
    end
    chk("drained_valid", 32'(ras_valid), 32'd0);
    pred(T_RET, 32'h0);
    chk("empty_pop_valid", 32'(ras_valid), 32'd0);
    chk("empty_pop_top", ras_top, 32'h0);
    chk("empty_pop_sp", 32'(dut.spec_q.sp), 32'd1);

    do_reset();
    pred(T_RET, 32'h0);
    chk("ret_empty_sp", 32'(dut.spec_q.sp), 32'd0);
    chk("ret_empty_top", ras_top, 32'h0);

    pred(T_CALL, 32'h500);
    pred(T_CALL, 32'h600);
    idle();
    cmt_valid = 1'b1; cmt_ins_type = T_CALL; cmt_pc = 32'h400;
    tick();
    idle();
    chk("spec_before_repair", ras_top, 32'h604);
    chk("cmt_count", 32'(dut.cmt_q.count), 32'd1);
    repair_valid = 1'b1; repair_ins_type = T_JUMP; repair_pc = 32'h999;
    tick();
    idle();
    chk("repair_jump_top", ras_top, 32'h404);
    chk("repair_jump_count", 32'(dut.spec_q.count), 32'd1);

    repair_valid = 1'b1; repair_ins_type = T_CALL; repair_pc = 32'h700;
    pred_valid = 1'b1; pred_ins_type = T_CALL; pred_pc = 32'h800;
    cmt_valid = 1'b1; cmt_ins_type = T_CALL; cmt_pc = 32'h300;
    tick();
    idle();
    chk("repair_call_top", ras_top, 32'h704);
    chk("repair_call_count", 32'(dut.spec_q.count), 32'd3);
    pred(T_RET, 32'h0);
    chk("after_repair_pop1", ras_top, 32'h304);
    pred(T_RET, 32'h0);
    chk("after_repair_pop2", ras_top, 32'h404);

    reset = 1'b1;
    pred_valid = 1'b1; pred_ins_type = T_CALL; pred_pc = 32'hA00;
    cmt_valid = 1'b1; cmt_ins_type = T_CALL; cmt_pc = 32'hB00;
    tick();
    idle();
    chk("reset_pri_valid", 32'(ras_valid), 32'd0);
    chk("reset_pri_top", ras_top, 32'h0);
    chk("reset_pri_cmt", 32'(dut.cmt_q.count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ras.md
RAS -- requirements
Module: ras

Interface
REQ-001 SHALL have parameter RASNUM, default 8, stack depth (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port reset  input  1  synchronous active-high reset.
REQ-004 SHALL have port pred_valid  input  1  fetch-side predicted instruction accepted this cycle.
REQ-005 SHALL have port pred_ins_type  input  3  BTB instruction type of the predicted slot.
REQ-006 SHALL have port pred_pc  input  32  PC of the predicted slot.
REQ-007 SHALL have port ras_top  output  32  predicted return target.
REQ-008 SHALL have port ras_valid  output  1  speculative stack non-empty.
REQ-009 SHALL have port cmt_valid  input  1  branch-class instruction committed.
REQ-010 SHALL have port cmt_ins_type  input  3  type of the committed instruction.
REQ-011 SHALL have port cmt_pc  input  32  PC of the committed instruction.
REQ-012 SHALL have port repair_valid  input  1  backend mispredict; rebuild speculative state.
REQ-013 SHALL have port repair_ins_type  input  3  type of the mispredicted instruction.
REQ-014 SHALL have port repair_pc  input  32  PC of the mispredicted instruction.

Function
REQ-015 SHALL hold two stacks: speculative (entries, sp, count) and committed (same shape).
REQ-016 SHALL treat type CALL as push of pc+4 (32-bit wrap) and RETURN as pop; all other types cause no change.
REQ-017 SHALL drive ras_top = speculative entry[sp-1 mod RASNUM] when count>0, else 32'b0, combinationally.
REQ-018 SHALL drive ras_valid = (count != 0) combinationally.
REQ-019 SHALL make push/pop visible on ras_top the cycle after pred_valid.
REQ-020 SHALL on push write entry[sp], sp <= sp+1 mod RASNUM, count <= min(count+1, RASNUM); full push overwrites oldest.
REQ-021 SHALL on pop with count>0 do sp <= sp-1 mod RASNUM, count <= count-1; pop on empty leaves state unchanged.
REQ-022 SHALL update the committed stack from cmt_* with the same push/pop rules, independent of pred and repair.
REQ-023 SHALL on repair_valid load speculative <= committed-after-same-cycle-commit, then apply repair_ins_type/repair_pc.
REQ-024 SHALL give repair priority over pred_valid in the same cycle; that pred is discarded.

Reset
REQ-025 SHALL on reset clear sp and count of both stacks, forcing ras_valid=0, ras_top=0 next cycle; entry contents need not reset.
REQ-026 SHALL let reset override all simultaneous pred/cmt/repair inputs.

Configuration
REQ-027 SHALL, with RAS_PERF_CNT_EN defined, add outputs ras_push_cnt and ras_pop_cnt (32 bits each) counting speculative pushes and non-empty pops, reset to 0, wrapping.
REQ-028 SHALL, without RAS_PERF_CNT_EN, omit those ports and counters entirely, with no other behavioural change.

Structure
REQ-029 SHALL take the 3-bit type encoding from the shared predictor package: NONE=000, BRANCH=001, JUMP=010, CALL=011, RETURN=100, INDIRECT=101; the BTB uses the same encoding.
REQ-030 SHALL place RASNUM default and the ras state struct (entries, sp, count) in that package.
REQ-031 SHALL implement the push/pop next-state logic as one sub-module ras_step, instantiated for the speculative, commit and repair paths.

Verification
REQ-032 SHALL cover: reset, pred CALL pc=0x1C000000 -> next cycle ras_top=0x1C000004, ras_valid=1.
REQ-033 SHALL cover: RASNUM+1 calls pc=0x100,0x200,...,0x900 -> count=8, ras_top=0x904, eight pops end at 0x204, ninth pop leaves ras_valid=0.
REQ-034 SHALL cover: RETURN on empty stack -> ras_top=0, ras_valid=0, no sp change.
REQ-035 SHALL cover: commit CALL 0x400, speculative CALLs 0x500,0x600, repair JUMP -> ras_top=0x404, count=1.
REQ-036 SHALL cover: repair CALL 0x700 with same-cycle pred CALL 0x800 and commit CALL 0x300 -> ras_top=0x704, next entry 0x304, 0x804 never pushed.
REQ-037 SHALL cover: reset asserted with pred CALL same cycle -> ras_valid=0 next cycle.
